ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ahb_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter: re-arbitrates only at burst/transfer boundaries,
// honours locked sequences and tracks the data-phase owner for response routing.
module ahb_arbiter #(
    parameter int NumManagers = 4,
    parameter int IdxWidth    = $clog2(NumManagers)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NumManagers-1:0] req,
    input  logic [1:0]             busTrans,
    input  logic [2:0]             busBurst,
    input  logic                   busLock,
    input  logic                   busReady,
    output logic [NumManagers-1:0] grant,
    output logic [IdxWidth-1:0]    owner,
    output logic [IdxWidth-1:0]    dataOwner,
    output logic                   lockHeld
);

    localparam logic [1:0]          TRANS_IDLE   = 2'b00;
    localparam logic [1:0]          TRANS_NONSEQ = 2'b10;
    localparam logic [1:0]          TRANS_SEQ    = 2'b11;
    localparam logic [2:0]          BURST_SINGLE = 3'b000;
    localparam logic [2:0]          BURST_INCR   = 3'b001;
    localparam logic [IdxWidth:0]   NUM_M        = (IdxWidth+1)'(NumManagers);

    typedef enum logic [1:0] {
        ST_PARKED,
        ST_OWNED,
        ST_BURST,
        ST_LOCKED
    } state_t;

    state_t                 r_state;
    logic [NumManagers-1:0] r_grant;
    logic [IdxWidth-1:0]    r_owner;
    logic [IdxWidth-1:0]    r_data_owner;
    logic [IdxWidth-1:0]    r_rr_ptr;
    logic                   r_lock_held;
    logic                   r_incr_mode;
    logic [3:0]             r_beats_left;

    logic                   w_nonseq;
    logic                   w_seq;
    logic                   w_accepted;
    logic                   w_lock_set;
    logic                   w_lock_clr;
    logic                   w_lock_next;
    logic                   w_arb_point;
    logic [3:0]             w_burst_beats;
    logic [IdxWidth-1:0]    w_cand [NumManagers];
    logic [NumManagers-1:0] w_hit;
    logic                   w_found;
    logic [IdxWidth-1:0]    w_winner;
    logic [IdxWidth-1:0]    w_next_owner;
    logic [IdxWidth:0]      w_inc;
    logic [IdxWidth-1:0]    w_next_ptr;
    logic [NumManagers-1:0] w_next_grant;

    assign w_nonseq   = busReady && (busTrans == TRANS_NONSEQ);
    assign w_seq      = busReady && (busTrans == TRANS_SEQ);
    assign w_accepted = w_nonseq || w_seq;
    assign w_lock_set = w_accepted && busLock;
    assign w_lock_clr = busReady && !busLock;

    always_comb begin
        w_lock_next = r_lock_held;
        if (w_lock_set && w_lock_clr) begin
            w_lock_next = (busTrans != TRANS_IDLE);
        end else if (w_lock_set) begin
            w_lock_next = 1'b1;
        end else if (w_lock_clr) begin
            w_lock_next = 1'b0;
        end
    end

    // Lock state as it will be after this cycle, so the first locked transfer
    // already blocks arbitration and the releasing cycle may arbitrate.
    assign w_arb_point = busReady && !w_lock_next &&
                         ((busTrans == TRANS_IDLE) ||
                          (w_nonseq && (busBurst == BURST_SINGLE)) ||
                          (w_seq && (r_beats_left == 4'd1) && !r_incr_mode));

    always_comb begin
        case (busBurst[2:1])
            2'b01:   w_burst_beats = 4'd3;
            2'b10:   w_burst_beats = 4'd7;
            2'b11:   w_burst_beats = 4'd15;
            default: w_burst_beats = 4'd0;
        endcase
    end

    // Candidate gi is the manager searched gi-th, starting at the pointer.
    generate
        for (genvar gi = 0; gi < NumManagers; gi++) begin : g_cand
            logic [IdxWidth:0] w_sum;
            assign w_sum       = {1'b0, r_rr_ptr} + (IdxWidth+1)'(gi);
            assign w_cand[gi]  = (w_sum >= NUM_M) ? IdxWidth'(w_sum - NUM_M)
                                                  : w_sum[IdxWidth-1:0];
            assign w_hit[gi]   = req[w_cand[gi]];
        end
    endgenerate

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = NumManagers - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_found  = 1'b1;
                w_winner = w_cand[i];
            end
        end
    end

    assign w_next_owner = w_found ? w_winner : '0;
    assign w_inc        = {1'b0, w_next_owner} + (IdxWidth+1)'(1);
    assign w_next_ptr   = (w_inc >= NUM_M) ? '0 : w_inc[IdxWidth-1:0];

    always_comb begin
        w_next_grant               = '0;
        w_next_grant[w_next_owner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_PARKED;
            r_grant      <= NumManagers'(1);
            r_owner      <= '0;
            r_data_owner <= '0;
            r_rr_ptr     <= '0;
            r_lock_held  <= 1'b0;
            r_beats_left <= 4'd0;
            r_incr_mode  <= 1'b0;
        end else begin
            if (busReady) begin
                r_data_owner <= r_owner;
            end
            r_lock_held <= w_lock_next;

            if (w_nonseq) begin
                r_beats_left <= w_burst_beats;
                r_incr_mode  <= (busBurst == BURST_INCR);
            end else if (w_seq && (r_beats_left != 4'd0)) begin
                r_beats_left <= r_beats_left - 4'd1;
            end

            if (w_arb_point) begin
                r_grant  <= w_next_grant;
                r_owner  <= w_next_owner;
                r_rr_ptr <= w_next_ptr;
            end

            if (w_lock_next && !r_lock_held) begin
                r_state <= ST_LOCKED;
            end else if (w_arb_point) begin
                r_state <= w_found ? ST_OWNED : ST_PARKED;
            end else if ((r_state == ST_LOCKED) && !w_lock_next) begin
                r_state <= ST_OWNED;
            end else if ((r_state == ST_OWNED) && w_nonseq && (busBurst != BURST_SINGLE)) begin
                r_state <= ST_BURST;
            end
        end
    end

    assign grant     = r_grant;
    assign owner     = r_owner;
    assign dataOwner = r_data_owner;
    assign lockHeld  = r_lock_held;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: a transfer-level model checked every cycle,
// plus hand-computed expected grant/dataOwner/lockHeld values per vector.
module tb_ahb_arbiter;

    localparam int NM = 4;
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSQ = 2'd2, SEQ = 2'd3;
    localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, INCR4 = 3'b011,
                           INCR8 = 3'b101, INCR16 = 3'b111;

    logic          clk = 1'b0;
    logic          reset;
    logic [NM-1:0] req;
    logic [1:0]    busTrans;
    logic [2:0]    busBurst;
    logic          busLock;
    logic          busReady;
    logic [NM-1:0] grant;
    logic [1:0]    owner;
    logic [1:0]    dataOwner;
    logic          lockHeld;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int lit_g    = -1;
    int lit_d    = -1;
    int lit_l    = -1;

    int m_owner, m_downer, m_beats;
    bit m_incr, m_lock, m_fresh;

    ahb_arbiter #(.NumManagers(NM)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .busTrans  (busTrans),
        .busBurst  (busBurst),
        .busLock   (busLock),
        .busReady  (busReady),
        .grant     (grant),
        .owner     (owner),
        .dataOwner (dataOwner),
        .lockHeld  (lockHeld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    // Transfer-level model: who should own the bus after this edge.
    task automatic model_step();
        bit acc, arb, nl;
        int start, win, idx, b, rq;
        if (reset) begin
            m_owner = 0; m_downer = 0; m_beats = 0;
            m_incr = 0; m_lock = 0; m_fresh = 1;
            return;
        end
        b   = int'(busBurst);
        rq  = int'(req);
        acc = busReady && (busTrans == NSQ || busTrans == SEQ);
        nl  = m_lock;
        if (acc && busLock) nl = 1;
        else if (busReady && !busLock) nl = 0;
        arb = busReady && !nl &&
              (busTrans == IDLE ||
               (acc && busTrans == NSQ && b == 0) ||
               (acc && busTrans == SEQ && m_beats == 1 && !m_incr));
        if (busReady) m_downer = m_owner;
        if (acc && busTrans == NSQ) begin
            m_incr  = (b == 1);
            m_beats = (b >= 2) ? (1 << (b / 2 + 1)) - 1 : 0;
        end else if (acc && m_beats > 0) begin
            m_beats--;
        end
        if (arb) begin
            start = m_fresh ? 0 : m_owner + 1;
            win = -1;
            for (int k = 0; k < NM; k++) begin
                idx = (start + k) % NM;
                if (win < 0 && ((rq >> idx) & 1) == 1) win = idx;
            end
            m_owner = (win < 0) ? 0 : win;
            m_fresh = 0;
        end
        m_lock = nl;
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        cyc++;
        $display("cyc %0d rst=%b req=%b trans=%0d burst=%0d lock=%b rdy=%b -> grant=%b owner=%0d dOwner=%0d lockHeld=%b",
                 cyc, reset, req, busTrans, busBurst, busLock, busReady, grant, owner, dataOwner, lockHeld);
        chk("grant", int'(grant), 1 << m_owner);
        chk("owner", int'(owner), m_owner);
        chk("dataOwner", int'(dataOwner), m_downer);
        chk("lockHeld", int'(lockHeld), int'(m_lock));
        if (lit_g >= 0) chk("lit_grant", int'(grant), lit_g);
        if (lit_d >= 0) chk("lit_dataOwner", int'(dataOwner), lit_d);
        if (lit_l >= 0) chk("lit_lockHeld", int'(lockHeld), lit_l);
    end

    // Apply one cycle of bus inputs; eg/ed/el are the values expected after it.
    task automatic drive(input logic [NM-1:0] r, input logic [1:0] t, input logic [2:0] bu,
                         input logic l, input logic rdy,
                         input int eg = -1, input int ed = -1, input int el = -1);
        req = r; busTrans = t; busBurst = bu; busLock = l; busReady = rdy;
        lit_g = eg; lit_d = ed; lit_l = el;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; req = '0; busTrans = IDLE; busBurst = SINGLE;
        busLock = 1'b0; busReady = 1'b1;
        @(negedge clk);
        drive(4'b0000, IDLE, SINGLE, 0, 1, 1, 0, 0);
        drive(4'b1111, SEQ, INCR8, 1, 1, 1, 0, 0);
        reset = 1'b0;

        // Round robin with everyone requesting
        drive(4'b1111, IDLE, SINGLE, 0, 1, 1);
        drive(4'b1111, IDLE, SINGLE, 0, 1, 2);
        drive(4'b1111, IDLE, SINGLE, 0, 1, 4);
        drive(4'b1111, IDLE, SINGLE, 0, 1, 8);
        drive(4'b1111, IDLE, SINGLE, 0, 1, 1);

        // Manager 1 INCR8 burst held to completion
        drive(4'b0110, IDLE, SINGLE, 0, 1, 2);
        drive(4'b0110, NSQ, INCR8, 0, 1, 2, 1);
        for (int k = 1; k <= 6; k++) begin
            drive(4'b0110, SEQ, INCR8, 0, 1, 2);
            if (k == 3) drive(4'b0110, BUSY, INCR8, 0, 1, 2);
        end
        drive(4'b0110, SEQ, INCR8, 0, 1, 4, 1);

        // Wait states inside a 4-beat burst
        drive(4'b0110, NSQ, INCR4, 0, 1, 4, 2);
        drive(4'b0110, SEQ, INCR4, 0, 1, 4, 2);
        for (int k = 0; k < 3; k++) drive(4'b0110, SEQ, INCR4, 0, 0, 4, 2);
        drive(4'b0110, SEQ, INCR4, 0, 1, 4, 2);
        drive(4'b0110, SEQ, INCR4, 0, 1, 2, 2);
        drive(4'b0110, IDLE, SINGLE, 0, 0, 2, 2);
        drive(4'b0110, IDLE, SINGLE, 0, 1, 4, 1);

        // Locked singles by manager 2
        for (int k = 0; k < 3; k++) drive(4'b1111, NSQ, SINGLE, 1, 1, 4, -1, 1);
        drive(4'b1111, IDLE, SINGLE, 1, 1, 4, -1, 1);
        drive(4'b1111, IDLE, SINGLE, 0, 0, 4, -1, 1);
        drive(4'b1111, IDLE, SINGLE, 0, 1, 8, -1, 0);

        // Park, then reset in beat 5 of a locked INCR16
        drive(4'b0000, IDLE, SINGLE, 0, 1, 1);
        drive(4'b0100, IDLE, SINGLE, 0, 1, 4);
        drive(4'b1111, NSQ, INCR16, 1, 1, 4, -1, 1);
        for (int k = 0; k < 3; k++) drive(4'b1111, SEQ, INCR16, 1, 1, 4, -1, 1);
        reset = 1'b1;
        drive(4'b1111, SEQ, INCR16, 1, 1, 1, 0, 0);
        reset = 1'b0;
        drive(4'b1111, IDLE, SINGLE, 0, 1, 1);
        drive(4'b1111, IDLE, SINGLE, 0, 1, 2);

        // Early termination of INCR4 by a new NONSEQ
        drive(4'b0011, NSQ, INCR4, 0, 1, 2);
        drive(4'b0011, SEQ, INCR4, 0, 1, 2);
        drive(4'b0011, NSQ, INCR4, 0, 1, 2);
        drive(4'b0011, SEQ, INCR4, 0, 1, 2);
        drive(4'b0011, SEQ, INCR4, 0, 1, 2);
        drive(4'b0011, SEQ, INCR4, 0, 1, 1);

        // Undefined-length INCR holds until IDLE
        drive(4'b0011, NSQ, INCR, 0, 1, 1);
        for (int k = 0; k < 20; k++) begin
            drive(4'b0011, SEQ, INCR, 0, 1, 1);
            if (k == 9) drive(4'b0011, BUSY, INCR, 0, 1, 1);
        end
        drive(4'b0011, IDLE, SINGLE, 0, 1, 2);
        drive(4'b0011, NSQ, SINGLE, 0, 1, 1);
        drive(4'b0000, IDLE, SINGLE, 0, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
